// File: rtl/mul_ctrl.sv
// mul_ctrl: iterative shift-add multiplier controller that stalls decode while a MUL is in flight.
// Build option: define MUL_CTRL_RADIX4_EN to retire two multiplier bits per BUSY cycle.
//
// state | meaning
// IDLE  | waiting for a MUL from decode
// BUSY  | shift-add steps running, decode held
// DONE  | one-cycle writeback pulse
module mul_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CW = $clog2(XLEN) + 1;
`ifdef MUL_CTRL_RADIX4_EN
  localparam int STEPS = XLEN / 2;
  localparam int SHIFT = 2;
`else
  localparam int STEPS = XLEN;
  localparam int SHIFT = 1;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] w_partial;
  logic [CW-1:0]   r_cnt;
  logic [4:0]      r_rd;
  logic [4:0]      r_rd_out;
  logic            w_accept;
  logic            w_step;
  logic            w_done;

  always_comb begin
`ifdef MUL_CTRL_RADIX4_EN
    w_partial = (r_mplier[0] ? r_mcand : '0) + (r_mplier[1] ? (r_mcand << 1) : '0);
`else
    w_partial = r_mplier[0] ? r_mcand : '0;
`endif
  end

  // flush and reset qualify every state action so a killed op never stalls or writes back
  assign w_accept = !rst && !flush_i && valid_i && (r_state == IDLE);
  assign w_step   = !rst && !flush_i && (r_state == BUSY);
  assign w_done   = !rst && !flush_i && (r_state == DONE);

  always_comb begin
    w_state_nxt    = r_state;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    result_o       = r_result;
    rd_o           = r_rd_out;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = BUSY;
        stall_o = w_accept;
      end
      BUSY: begin
        if (flush_i)                 w_state_nxt = IDLE;
        else if (r_cnt == CW'(1))    w_state_nxt = DONE;
        stall_o = w_step;
      end
      DONE: begin
        w_state_nxt    = IDLE;
        result_valid_o = w_done;
        if (w_done) begin
          result_o = r_acc;
          rd_o     = r_rd;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_rd     <= '0;
      r_rd_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mcand  <= rs1_data_i;
        r_mplier <= rs2_data_i;
        r_rd     <= rd_i;
        r_acc    <= '0;
        r_cnt    <= CW'(STEPS);
      end else if (w_step) begin
        r_acc    <= r_acc + w_partial;
        r_mcand  <= r_mcand << SHIFT;
        r_mplier <= r_mplier >> SHIFT;
        r_cnt    <= r_cnt - CW'(1);
      end
      // holding copy so result_o/rd_o keep the last writeback between pulses
      if (w_done) begin
        r_result <= r_acc;
        r_rd_out <= r_rd;
      end
    end
  end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port valid_i, input, 1: decode-stage instruction is a MUL (decoder mul flag AND stage valid).
REQ-005 SHALL have port flush_i, input, 1: kill the in-flight MUL (branch/jump redirect).
REQ-006 SHALL have port rs1_data_i, input, XLEN: multiplicand operand.
REQ-007 SHALL have port rs2_data_i, input, XLEN: multiplier operand.
REQ-008 SHALL have port rd_i, input, 5: destination register of the MUL.
REQ-009 SHALL have port stall_o, output, 1: hold the decode stage and everything upstream.
REQ-010 SHALL have port result_valid_o, output, 1: one-cycle pulse, result_o and rd_o are valid for writeback.
REQ-011 SHALL have port result_o, output, XLEN: low XLEN bits of rs1*rs2.
REQ-012 SHALL have port rd_o, output, 5: latched destination register.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE: valid_i=1 and flush_i=0 -> latch rs1, rs2 and rd, clear the accumulator, load the step counter, go to BUSY; otherwise stay in IDLE.
REQ-015 BUSY: each cycle, if multiplier LSB=1 then acc += multiplicand (mod 2^XLEN); multiplicand <<= 1; multiplier >>= 1; counter decrements.
REQ-016 BUSY: go to DONE on the cycle the counter reaches its last step; baseline is XLEN steps (32 BUSY cycles).
REQ-017 DONE: result_valid_o=1 for exactly one cycle; result_o=acc; rd_o=latched rd; next state is IDLE unconditionally.
REQ-018 DONE SHALL ignore valid_i; the still-held MUL must not relaunch.
REQ-019 stall_o SHALL be combinational: (IDLE and valid_i and not flush_i) or BUSY; 0 in DONE.
REQ-020 Total latency SHALL be XLEN+1 cycles from the accept edge to the result_valid_o cycle; no early termination for zero or small operands.
REQ-021 The result SHALL be the low XLEN bits of the product and sign-agnostic; rs1/rs2 input changes after accept SHALL NOT affect it.
REQ-022 result_o and rd_o SHALL hold their last value until the next DONE.
REQ-023 flush_i=1 in BUSY or DONE SHALL force IDLE next cycle, suppress result_valid_o in that cycle, and drop stall_o in that cycle.
REQ-024 flush_i and valid_i both high in IDLE: flush wins, no accept, stall_o=0.
REQ-025 A new valid_i in the cycle right after DONE (IDLE) SHALL be accepted normally, giving back-to-back MULs.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE from any state, including mid-BUSY, and discard the operation.
REQ-027 Reset values: stall_o=0, result_valid_o=0, result_o=0, rd_o=0, accumulator=0, counter=0.
REQ-028 While rst=1, stall_o and result_valid_o SHALL be 0 regardless of valid_i.

Configuration
REQ-029 Macro MUL_CTRL_RADIX4_EN defined: each BUSY cycle retires 2 multiplier bits (acc += multiplicand*multiplier[1:0]; multiplicand <<= 2; multiplier >>= 2); BUSY lasts XLEN/2 cycles; latency is XLEN/2+1.
REQ-030 Macro MUL_CTRL_RADIX4_EN undefined: radix-2 behaviour per REQ-015/016/020.
REQ-031 Results SHALL be bit-identical in both configurations; only latency differs.

Verification
REQ-032 rs1=7, rs2=6, rd=5, valid_i held while stall_o=1 -> stall_o high 33 cycles (17 radix-4), then result_valid_o=1, result_o=42, rd_o=5 for one cycle.
REQ-033 rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result_o=0x00000001; rs1=0x80000000, rs2=2 -> result_o=0.
REQ-034 flush_i pulsed at BUSY cycle 10 -> next cycle IDLE, stall_o=0, no result_valid_o pulse; the following MUL is correct.
REQ-035 rst=1 at BUSY cycle 5 -> next cycle all outputs at reset values; a subsequent MUL 3*4 -> result_o=12.
REQ-036 Two back-to-back MULs (3*5 rd=1, then 9*9 rd=2) -> two result_valid_o pulses, 34 cycles apart (18 radix-4), with 15/rd=1 then 81/rd=2.
REQ-037 valid_i=1 and flush_i=1 together in IDLE -> no accept, stall_o=0, state stays IDLE.
